// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: runs ahead of the fetch stage, buffering
// {address, word} pairs and abandoning the stream when the fetch PC diverges.
module prefetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [ADDR_WIDTH-1:0]     i_pc,
  input  logic                      i_consume,
  output logic [DATA_WIDTH-1:0]     o_instruction,
  output logic                      o_valid,
  output logic                      o_mem_req,
  output logic [ADDR_WIDTH-1:0]     o_mem_address,
  input  logic                      i_mem_ack,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  output logic [$clog2(DEPTH):0]    o_debug_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] discard_addr_q, discard_addr_d;

  logic [ADDR_WIDTH-1:0] entry_addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data_q [DEPTH];

  logic                  not_empty;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] expected_pc;
  logic                  redirect;
  logic                  head_match;
  logic                  pop;
  logic                  push;
  logic [CNT_W-1:0]      count_after_pop;
  logic [CNT_W-1:0]      count_after_push;

  // ---------------------------------------------------------------------------
  // Head view and redirect detection
  // ---------------------------------------------------------------------------
  assign not_empty   = (count_q != '0);
  assign head_addr   = entry_addr_q[head_q];
  assign head_data   = entry_data_q[head_q];
  assign expected_pc = not_empty ? head_addr : fetch_pc_q;
  assign redirect    = (i_pc != expected_pc);
  assign head_match  = not_empty && (head_addr == i_pc);

  // A matching head already implies no redirect, so a pop never races a flush.
  assign pop              = i_consume && head_match;
  assign count_after_pop  = count_q - CNT_W'(pop);
  assign count_after_push = count_after_pop + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_valid       = head_match;
  assign o_instruction = not_empty ? head_data : '0;
  assign o_mem_req     = (state_q != ST_IDLE);
  assign o_mem_address = (state_q == ST_DISCARD) ? discard_addr_q : fetch_pc_q;
  assign o_debug_count = count_q;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    discard_addr_d = discard_addr_q;
    push           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!redirect && (count_after_pop < DEPTH_CNT)) begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (i_mem_ack) begin
          if (redirect) begin
            state_d = ST_IDLE;
          end else begin
            push    = 1'b1;
            state_d = (count_after_push < DEPTH_CNT) ? ST_REQ : ST_IDLE;
          end
        end else if (redirect) begin
          // The bus transaction cannot be withdrawn; finish it under the old address.
          state_d        = ST_DISCARD;
          discard_addr_d = fetch_pc_q;
        end
      end

      ST_DISCARD: begin
        if (i_mem_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Queue pointers, occupancy and fetch address
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fetch_pc_d = fetch_pc_q;

    if (redirect) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = i_pc;
    end else begin
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + WORD_STEP;
      end
      count_d = count_q - CNT_W'(pop) + CNT_W'(push);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      fetch_pc_q     <= '0;
      discard_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      fetch_pc_q     <= fetch_pc_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  // NOTE: entry storage has no reset; occupancy gates every read, so stale contents are never visible.
  always_ff @(posedge i_clk) begin
    if (push) begin
      entry_addr_q[tail_q] <= fetch_pc_q;
      entry_data_q[tail_q] <= i_mem_data;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: fill, redirect, discard, wrap and a
// randomised-latency streaming run, all against bench-computed expectations.
module tb_prefetch_queue;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [15:0] i_pc;
  logic        i_consume;
  logic [31:0] o_instruction;
  logic        o_valid;
  logic        o_mem_req;
  logic [15:0] o_mem_address;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
  logic [2:0]  o_debug_count;

  prefetch_queue dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_pc          (i_pc),
    .i_consume     (i_consume),
    .o_instruction (o_instruction),
    .o_valid       (o_valid),
    .o_mem_req     (o_mem_req),
    .o_mem_address (o_mem_address),
    .i_mem_ack     (i_mem_ack),
    .i_mem_data    (i_mem_data),
    .o_debug_count (o_debug_count)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Memory responder state (auto mode) and request-hold tracking.
  bit          mem_auto;
  bit          mem_rand;
  int          mem_lat;
  int          wait_cnt;
  logic [15:0] req_log [$];
  bit          prev_pending;
  logic [15:0] prev_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] addr);
    return 32'hA000_0000 | {16'h0000, addr};
  endfunction

  // One clock: drive the memory (auto mode), take the edge, sample at +1.
  task automatic tick();
    if (mem_auto) begin
      if (o_mem_req) begin
        if (wait_cnt >= mem_lat) begin
          i_mem_ack  = 1'b1;
          i_mem_data = mem_word(o_mem_address);
          req_log.push_back(o_mem_address);
          wait_cnt   = 0;
          if (mem_rand) mem_lat = $urandom_range(0, 3);
        end else begin
          i_mem_ack  = 1'b0;
          i_mem_data = '0;
          wait_cnt++;
        end
      end else begin
        i_mem_ack = 1'b0;
        wait_cnt  = 0;
      end
    end
    prev_pending = o_mem_req && !i_mem_ack;
    prev_addr    = o_mem_address;
    @(posedge i_clk);
    #1;
    if (prev_pending) begin
      check("req_hold", {31'b0, o_mem_req}, 32'd1);
      check("addr_hold", {16'b0, o_mem_address}, {16'b0, prev_addr});
    end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #2;
    check("rst_req",   {31'b0, o_mem_req}, 32'd0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_instr", o_instruction, 32'd0);
    check("rst_count", {29'b0, o_debug_count}, 32'd0);
    prev_pending = 1'b0;
    wait_cnt     = 0;
    req_log.delete();
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_addr [4];
    int          n;
    int          delivered;
    int          max_cnt;
    bit          got;

    exp_addr = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
    i_reset_n = 1'b0;
    i_pc      = '0;
    i_consume = 1'b0;
    i_mem_ack = 1'b0;
    i_mem_data = '0;
    mem_auto  = 1'b1;
    mem_rand  = 1'b0;
    mem_lat   = 1;
    #1;
    do_reset();

    // Fill from reset with one-cycle ack latency.
    repeat (14) tick();
    check("fill_nreq", req_log.size(), 32'd4);
    if (req_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("fill_addr", {16'b0, req_log[i]}, {16'b0, exp_addr[i]});
    end
    check("fill_req",   {31'b0, o_mem_req}, 32'd0);
    check("fill_count", {29'b0, o_debug_count}, 32'd4);
    check("fill_valid", {31'b0, o_valid}, 32'd1);
    check("fill_instr", o_instruction, 32'hA000_0000);

    // Redirect a full queue.
    i_pc = 16'h0040;
    tick();
    check("flush_count", {29'b0, o_debug_count}, 32'd0);
    check("flush_valid", {31'b0, o_valid}, 32'd0);
    n = 0;
    while (!o_mem_req && n < 3) begin tick(); n++; end
    check("flush_req",  {31'b0, o_mem_req}, 32'd1);
    check("flush_addr", {16'b0, o_mem_address}, 32'h0040);
    n = 0;
    while (!o_valid && n < 6) begin tick(); n++; end
    check("flush_word", o_instruction, 32'hA000_0040);

    // Streaming with random latency: words must arrive in order, none skipped.
    do_reset();
    mem_rand  = 1'b1;
    mem_lat   = $urandom_range(0, 3);
    i_pc      = 16'h1000;
    i_consume = 1'b1;
    #1;
    delivered = 0;
    max_cnt   = 0;
    for (int c = 0; c < 200; c++) begin
      got = o_valid;
      if (int'(o_debug_count) > max_cnt) max_cnt = int'(o_debug_count);
      if (got) begin
        check("stream_word", o_instruction, mem_word(i_pc));
        delivered++;
      end
      tick();
      if (got) i_pc = i_pc + 16'd4;
      #1;
    end
    check("stream_enough", {31'b0, delivered >= 40}, 32'd1);
    check("stream_maxcnt", {31'b0, max_cnt <= 4}, 32'd1);
    for (int k = 0; k < req_log.size(); k++)
      check("stream_seq", {16'b0, req_log[k]}, {16'b0, 16'h1000 + 16'(4 * k)});
    check("stream_inflight", {31'b0, (req_log.size() - delivered) <= 4}, 32'd1);

    // Reset with a request outstanding; a late ack is ignored.
    mem_auto  = 1'b0;
    mem_rand  = 1'b0;
    i_mem_ack = 1'b0;
    i_consume = 1'b0;
    do_reset();
    i_pc = 16'h0000;
    tick();
    check("rstreq_req", {31'b0, o_mem_req}, 32'd1);
    tick();
    do_reset();
    i_mem_ack  = 1'b1;
    i_mem_data = 32'h1234_5678;
    tick();
    i_mem_ack = 1'b0;
    check("late_ack_count", {29'b0, o_debug_count}, 32'd0);
    check("late_ack_req",   {31'b0, o_mem_req}, 32'd1);
    check("late_ack_addr",  {16'b0, o_mem_address}, 32'h0000);

    // Redirect while 0x0008 is pending; ack arrives three cycles later.
    do_reset();
    i_pc = 16'h0000;
    tick();
    i_mem_ack = 1'b1; i_mem_data = mem_word(16'h0000); tick();
    i_mem_data = mem_word(16'h0004); tick();
    i_mem_ack = 1'b0;
    check("disc_pending", {16'b0, o_mem_address}, 32'h0008);
    i_pc = 16'h0100;
    tick();
    check("disc_count", {29'b0, o_debug_count}, 32'd0);
    check("disc_valid", {31'b0, o_valid}, 32'd0);
    check("disc_addr0", {16'b0, o_mem_address}, 32'h0008);
    tick();
    check("disc_addr1", {16'b0, o_mem_address}, 32'h0008);
    tick();
    check("disc_addr2", {16'b0, o_mem_address}, 32'h0008);
    i_mem_ack = 1'b1; i_mem_data = 32'hBAD0_0008;
    tick();
    i_mem_ack = 1'b0;
    check("disc_idle",  {31'b0, o_mem_req}, 32'd0);
    check("disc_drop",  {29'b0, o_debug_count}, 32'd0);
    tick();
    check("disc_newreq", {16'b0, o_mem_address}, 32'h0100);
    i_mem_ack = 1'b1; i_mem_data = mem_word(16'h0100);
    tick();
    i_mem_ack = 1'b0;
    check("disc_valid1", {31'b0, o_valid}, 32'd1);
    check("disc_word",   o_instruction, 32'hA000_0100);
    check("disc_next",   {16'b0, o_mem_address}, 32'h0104);

    // Redirect coincident with ack: nothing pushed, back to idle.
    i_pc = 16'h0200;
    i_mem_ack = 1'b1; i_mem_data = mem_word(16'h0104);
    tick();
    i_mem_ack = 1'b0;
    check("coin_count", {29'b0, o_debug_count}, 32'd0);
    check("coin_req",   {31'b0, o_mem_req}, 32'd0);
    check("coin_valid", {31'b0, o_valid}, 32'd0);
    tick();
    check("coin_newreq", {31'b0, o_mem_req}, 32'd1);
    check("coin_addr",   {16'b0, o_mem_address}, 32'h0200);

    // Address wrap at the top of the space, then push+pop in one cycle.
    do_reset();
    i_pc = 16'hFFFC;
    tick();
    check("wrap_idle", {31'b0, o_mem_req}, 32'd0);
    tick();
    check("wrap_addr", {16'b0, o_mem_address}, 32'hFFFC);
    i_mem_ack = 1'b1; i_mem_data = mem_word(16'hFFFC);
    tick();
    i_mem_ack = 1'b0;
    check("wrap_count", {29'b0, o_debug_count}, 32'd1);
    check("wrap_valid", {31'b0, o_valid}, 32'd1);
    check("wrap_word",  o_instruction, 32'hA000_FFFC);
    check("wrap_next",  {16'b0, o_mem_address}, 32'h0000);
    i_consume = 1'b1;
    i_mem_ack = 1'b1; i_mem_data = mem_word(16'h0000);
    tick();
    i_mem_ack = 1'b0;
    i_consume = 1'b0;
    check("pushpop_count", {29'b0, o_debug_count}, 32'd1);
    i_pc = 16'h0000;
    #1;
    check("pushpop_valid", {31'b0, o_valid}, 32'd1);
    check("pushpop_word",  o_instruction, 32'hA000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
